dcm_lock_sequencer: RTL and testbench

Free-running-clock supervisor that sits beside `clock_gen` and turns its DCM lock indications into safe resets. It pulses the DCM reset, waits for lock with a timeout and automatic retry, qualifies lock as stable for a programmable hold time, and only then releases the system logic reset. It also re-sequences on any loss of lock and keeps saturating retry and loss counters for debug display.

---
 rtl/dcm_lock_sequencer_if.sv | 21 ++
 rtl/dcm_lock_sequencer.sv | 143 ++++++++++++++
 tb/tb_dcm_lock_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/dcm_lock_sequencer_if.sv
// Signal bundle between the DCM lock sequencer and the clock generator / status logic.
// The master side is the sequencer: it consumes the raw lock and drives resets and status.
interface dcm_lock_sequencer_if;
  logic       locked;
  logic       dcm_reset;
  logic       logic_reset;
  logic       ready;
  logic [7:0] retry_count;
  logic [7:0] loss_count;
  logic [1:0] state;

  modport master (
    input  locked,
    output dcm_reset, logic_reset, ready, retry_count, loss_count, state
  );

  modport slave (
    output locked,
    input  dcm_reset, logic_reset, ready, retry_count, loss_count, state
  );
endinterface

// File: rtl/dcm_lock_sequencer.sv
// Supervises DCM lock: pulses DCM reset, waits for lock with timeout/retry, qualifies
// lock for a hold time, then releases logic reset. Re-sequences on any lock loss.
module dcm_lock_sequencer #(
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES    = 1024
) (
  input logic                  clock,
  input logic                  reset_n,
  dcm_lock_sequencer_if.master bus
);
  localparam int CW = 20;
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_DCM_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_QUALIFY   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  logic [1:0]    r_sync;
  logic          w_lock_s;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0] r_hold, w_hold_nxt;
  logic [7:0]    r_retry, r_loss;
  logic          w_retry_inc, w_loss_inc;
  logic          w_timeout, w_qual_done;
  logic          r_dcm_reset, r_logic_reset;

  // locked comes from another clock domain's DCM chain
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], bus.locked};
  end

  assign w_lock_s    = r_sync[1];
  assign w_timeout   = (r_cnt == TO_LAST);
  assign w_qual_done = w_lock_s && (r_hold == HOLD_LAST);

  // Timeout outranks every transition except completed qualification, so a
  // flapping lock cannot push the retry point past TIMEOUT_CYCLES.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = r_hold;
    w_retry_inc = 1'b0;
    w_loss_inc  = 1'b0;
    case (r_state)
      S_DCM_RST: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (w_timeout) begin
          w_state_nxt = S_DCM_RST;
          w_cnt_nxt   = '0;
          w_hold_nxt  = '0;
          w_retry_inc = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_lock_s) begin
            w_state_nxt = S_QUALIFY;
            w_hold_nxt  = '0;
          end
        end
      end
      S_QUALIFY: begin
        if (w_qual_done) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
          w_hold_nxt  = '0;
        end else if (w_timeout) begin
          w_state_nxt = S_DCM_RST;
          w_cnt_nxt   = '0;
          w_hold_nxt  = '0;
          w_retry_inc = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_lock_s) begin
            w_hold_nxt = r_hold + 1'b1;
          end else begin
            w_state_nxt = S_WAIT_LOCK;
            w_hold_nxt  = '0;
          end
        end
      end
      S_RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = S_DCM_RST;
          w_cnt_nxt   = '0;
          w_loss_inc  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_DCM_RST;
        w_cnt_nxt   = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_DCM_RST;
      r_cnt         <= '0;
      r_hold        <= '0;
      r_dcm_reset   <= 1'b1;
      r_logic_reset <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_hold        <= w_hold_nxt;
      r_dcm_reset   <= (w_state_nxt == S_DCM_RST);
      r_logic_reset <= (w_state_nxt != S_RUN);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_retry <= 8'd0;
      r_loss  <= 8'd0;
    end else begin
      if (w_retry_inc && (r_retry != 8'hFF)) r_retry <= r_retry + 8'd1;
      if (w_loss_inc  && (r_loss  != 8'hFF)) r_loss  <= r_loss  + 8'd1;
    end
  end

  assign bus.dcm_reset   = r_dcm_reset;
  assign bus.logic_reset = r_logic_reset;
  assign bus.ready       = ~r_logic_reset;
  assign bus.retry_count = r_retry;
  assign bus.loss_count  = r_loss;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// Directed bench for dcm_lock_sequencer with RST=4, TIMEOUT=50, HOLD=8.
// Expected values are queued at stimulus time and popped when the output is sampled.
module tb_dcm_lock_sequencer;
  logic clock = 1'b0;
  logic reset_n;

  dcm_lock_sequencer_if bus ();

  dcm_lock_sequencer #(
    .RST_CYCLES     (4),
    .TIMEOUT_CYCLES (50),
    .HOLD_CYCLES    (8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed %0h with no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < limit) begin
      tick(1);
      n++;
    end
    if (bus.ready !== 1'b1) n = -1;
  endtask

  function automatic logic [31:0] snap();
    return {11'd0, bus.dcm_reset, bus.logic_reset, bus.ready, bus.state,
            bus.retry_count, bus.loss_count};
  endfunction

  initial begin
    int   n, hi_cnt, rise1, rise2, first_retry;
    logic prev, seen_ready, seen_run;
    logic [3:0] pat4;
    logic [2:0] pat3;

    // reset values
    bus.locked = 1'b0;
    reset_n    = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    push({11'd0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0});
    check("reset_state", snap());
    tick(2);
    reset_n = 1'b1;

    // clean start: dcm_reset across edges 1..4, lock arrives after edge 10
    for (int k = 0; k < 4; k++) begin
      tick(1);
      pat4[3-k] = bus.dcm_reset;
    end
    push(32'b1110);
    check("dcm_reset_pulse", {28'd0, pat4});
    tick(6);
    bus.locked = 1'b1;
    push(32'd11);
    wait_ready(100, n);
    check("clean_ready_latency", n);
    push({14'd0, 2'd3, 8'd0, 8'd0});
    check("clean_state_counts", {14'd0, bus.state, bus.retry_count, bus.loss_count});

    // one-cycle lock loss in RUN
    bus.locked = 1'b0;
    tick(1);
    pat3[2] = bus.logic_reset;
    bus.locked = 1'b1;
    tick(1);
    pat3[1] = bus.logic_reset;
    tick(1);
    pat3[0] = bus.logic_reset;
    push(32'b001);
    check("loss_logic_reset_timing", {29'd0, pat3});
    push({23'd0, 1'b1, 8'd1});
    check("loss_dcm_reset_count", {23'd0, bus.dcm_reset, bus.loss_count});
    push(32'd13);
    wait_ready(100, n);
    check("resequence_ready", n);

    // never locks: 300 cycles from a fresh reset
    bus.locked = 1'b0;
    reset_n    = 1'b0;
    #2 reset_n = 1'b1;
    hi_cnt = 0; rise1 = 0; rise2 = 0; prev = 1'b1; seen_ready = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      tick(1);
      if (bus.dcm_reset === 1'b1) hi_cnt++;
      if (bus.ready !== 1'b0) seen_ready = 1'b1;
      if (bus.dcm_reset === 1'b1 && prev === 1'b0) begin
        if (rise1 == 0) rise1 = c;
        else if (rise2 == 0) rise2 = c;
      end
      prev = bus.dcm_reset;
    end
    push(32'd54);
    check("nolock_first_retry_edge", rise1);
    push(32'd54);
    check("nolock_retry_period", rise2 - rise1);
    push(32'd23);
    check("nolock_dcm_reset_high_cycles", hi_cnt);
    push({23'd0, 1'b0, 8'd5});
    check("nolock_ready_retry", {23'd0, seen_ready, bus.retry_count});

    // saturation: retry 255 lands on edge 54*255
    tick(13769 - 300);
    push(32'd254);
    check("retry_before_sat", bus.retry_count);
    tick(1);
    push(32'd255);
    check("retry_at_sat", bus.retry_count);
    tick(54 * 6);
    push(32'd255);
    check("retry_holds_sat", bus.retry_count);

    // async reset while in QUALIFY
    bus.locked = 1'b1;
    n = 0;
    while (bus.state !== 2'd2 && n < 100) begin
      tick(1);
      n++;
    end
    push({22'd0, 2'd2, 8'd255});
    check("reach_qualify", {22'd0, bus.state, bus.retry_count});
    #1 reset_n = 1'b0;
    #1;
    push({11'd0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0});
    check("async_reset_outputs", snap());
    bus.locked = 1'b0;
    #1 reset_n = 1'b1;

    // flapping lock: high 5 / low 2
    seen_run = 1'b0; seen_ready = 1'b0; first_retry = 0;
    for (int c = 1; c <= 300; c++) begin
      bus.locked = ((c - 1) % 7) < 5;
      tick(1);
      if (bus.state === 2'd3) seen_run = 1'b1;
      if (bus.ready !== 1'b0) seen_ready = 1'b1;
      if (first_retry == 0 && bus.retry_count === 8'd1) first_retry = c;
    end
    push(32'd54);
    check("flap_first_timeout_edge", first_retry);
    push(32'd0);
    check("flap_never_run", {30'd0, seen_run, seen_ready});
    push(32'd5);
    check("flap_retry_count", bus.retry_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
